// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM encoding, reset/bubble defaults and the redirect-select helper.
package fetch_stage_pkg;

    typedef enum logic {
        FETCH_REQ  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

    // A jump wins over a branch raised in the same cycle.
    function automatic logic [31:0] redirect_target(
        input logic        jump_taken,
        input logic [31:0] jump_target,
        input logic [31:0] branch_target
    );
        return jump_taken ? jump_target : branch_target;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
// The fetch stage is the master; the memory is the slave.
interface fetch_stage_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;

    modport master (output IMemReq, output IMemAddr, input IMemAck, input IMemData);
    modport slave  (input IMemReq, input IMemAddr, output IMemAck, output IMemData);
endinterface

// File: rtl/fetch_stage_ifid_register.sv
// IF/ID pipeline register.
// Priority per edge: flush, then load, then bubble, otherwise hold.
module fetch_stage_ifid_register #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        load,
    input  logic        bubble,
    input  logic        flush,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pcplus4,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d   = load_instr;
            pcplus4_d = load_pcplus4;
            valid_d   = 1'b1;
        end else if (bubble) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            instr_q   <= NOP_WORD;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pcplus4_q;
    assign IFID_Valid       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select, imem handshake
// and control of the IF/ID register. PC+4 comes from an external incrementor.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               PCWrite,
    input  logic               BranchTaken,
    input  logic [31:0]        BranchTarget,
    input  logic               JumpTaken,
    input  logic [31:0]        JumpTarget,
    input  logic               Flush,
    fetch_stage_if.master      imem,
    output logic [31:0]        PC,
    input  logic [31:0]        PCPlus4,
    output logic [31:0]        IFID_PCPlus4,
    output logic [31:0]        IFID_Instruction,
    output logic               IFID_Valid,
    output logic               FetchBusy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pend_q, pend_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  hold_q, hold_d;

    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  ifid_instr;

    assign redirect    = BranchTaken | JumpTaken;
    assign redirect_pc = redirect_target(JumpTaken, JumpTarget, BranchTarget);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_pc_d   = pend_pc_q;
        hold_d      = hold_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_instr  = imem.IMemData;
        case (state_q)
            FETCH_REQ: begin
                if (imem.IMemAck) begin
                    if (redirect || pend_q) begin
                        // Returned word belongs to the abandoned path.
                        pc_d        = redirect ? redirect_pc : pend_pc_q;
                        pend_d      = 1'b0;
                        ifid_bubble = 1'b1;
                    end else if (PCWrite) begin
                        ifid_load = 1'b1;
                        pc_d      = PCPlus4;
                    end else begin
                        hold_d  = imem.IMemData;
                        state_d = FETCH_HOLD;
                    end
                end else begin
                    // Address must stay stable until ack, so park the redirect.
                    if (redirect) begin
                        pend_d    = 1'b1;
                        pend_pc_d = redirect_pc;
                    end
                    ifid_bubble = PCWrite;
                end
            end
            FETCH_HOLD: begin
                if (redirect) begin
                    pc_d        = redirect_pc;
                    state_d     = FETCH_REQ;
                    ifid_bubble = PCWrite;
                end else if (PCWrite) begin
                    ifid_load  = 1'b1;
                    ifid_instr = hold_q;
                    pc_d       = PCPlus4;
                    state_d    = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= FETCH_REQ;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
            hold_q    <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            hold_q    <= hold_d;
        end
    end

    fetch_stage_ifid_register #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid (
        .Clk              (Clk),
        .Rst              (Rst),
        .load             (ifid_load),
        .bubble           (ifid_bubble),
        .flush            (Flush),
        .load_instr       (ifid_instr),
        .load_pcplus4     (PCPlus4),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid)
    );

    assign imem.IMemReq  = (state_q == FETCH_REQ);
    assign imem.IMemAddr = pc_q;
    assign PC            = pc_q;
    assign FetchBusy     = imem.IMemReq & ~imem.IMemAck;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the fetch rules.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        PCWrite = 1'b0, BranchTaken = 1'b0, JumpTaken = 1'b0, Flush = 1'b0;
    logic [31:0] BranchTarget = 32'h0, JumpTarget = 32'h0;
    logic [31:0] PC, PCPlus4, IFID_PCPlus4, IFID_Instruction;
    logic        IFID_Valid, FetchBusy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    fetch_stage_if imem ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign PCPlus4       = PC + 32'd4;
    assign imem.IMemData = mem_word(imem.IMemAddr);
    initial imem.IMemAck = 1'b0;

    fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
        .Clk (Clk), .Rst (Rst), .PCWrite (PCWrite),
        .BranchTaken (BranchTaken), .BranchTarget (BranchTarget),
        .JumpTaken (JumpTaken), .JumpTarget (JumpTarget), .Flush (Flush),
        .imem (imem), .PC (PC), .PCPlus4 (PCPlus4),
        .IFID_PCPlus4 (IFID_PCPlus4), .IFID_Instruction (IFID_Instruction),
        .IFID_Valid (IFID_Valid), .FetchBusy (FetchBusy)
    );

    // Reference model: fetch PC, outstanding redirect, captured word, IF/ID contents.
    logic [31:0] m_pc, m_pend_pc, m_held, m_instr, m_pc4;
    bit          m_holding, m_pend, m_valid;

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 0; m_pend_pc = 32'h0; m_holding = 0; m_held = 32'h0;
        m_instr = NOP_WORD_DEFAULT; m_pc4 = 32'h0; m_valid = 0;
    endtask

    task automatic model_step(input bit pw, input bit ack, input bit bt, input logic [31:0] btgt,
                              input bit jt, input logic [31:0] jtgt, input bit fl);
        bit          redir = bt | jt;
        logic [31:0] tgt = jt ? jtgt : btgt;
        bit          deliver = 0, kill = 0;
        logic [31:0] word = 32'h0, word_pc4 = 32'h0;
        if (!m_holding && ack && (redir || m_pend)) begin
            m_pc = redir ? tgt : m_pend_pc;
            m_pend = 0;
            kill = 1;
        end else if (!m_holding && ack && pw) begin
            deliver = 1; word = mem_word(m_pc);
        end else if (!m_holding && ack) begin
            m_held = mem_word(m_pc); m_holding = 1;
        end else if (!m_holding) begin
            if (redir) begin m_pend = 1; m_pend_pc = tgt; end
            kill = pw;
        end else if (redir) begin
            m_pc = tgt; m_holding = 0; kill = pw;
        end else if (pw) begin
            deliver = 1; word = m_held; m_holding = 0;
        end
        if (deliver) begin
            word_pc4 = m_pc + 32'd4;
            m_pc     = m_pc + 32'd4;
        end
        if (fl || (kill && !deliver)) begin
            m_instr = NOP_WORD_DEFAULT; m_valid = 0;
        end else if (deliver) begin
            m_instr = word; m_pc4 = word_pc4; m_valid = 1;
        end
    endtask

    // One clock: drive inputs, check combinational outputs, step, check registered outputs.
    task automatic cycle(input bit pw, input bit ack, input bit bt, input logic [31:0] btgt,
                         input bit jt, input logic [31:0] jtgt, input bit fl);
        PCWrite = pw; imem.IMemAck = ack; BranchTaken = bt; BranchTarget = btgt;
        JumpTaken = jt; JumpTarget = jtgt; Flush = fl;
        #1;
        n_tests++;
        if (imem.IMemReq !== !m_holding) begin
            n_fail++; $display("FAIL req: got %b want %b", imem.IMemReq, !m_holding);
        end
        n_tests++;
        if (imem.IMemAddr !== m_pc) begin
            n_fail++; $display("FAIL addr: got %h want %h", imem.IMemAddr, m_pc);
        end
        n_tests++;
        if (FetchBusy !== (!m_holding && !ack)) begin
            n_fail++; $display("FAIL busy: got %b want %b", FetchBusy, !m_holding && !ack);
        end
        model_step(pw, ack, bt, btgt, jt, jtgt, fl);
        @(posedge Clk);
        #1;
        n_tests++;
        if (IFID_Valid !== m_valid || IFID_Instruction !== m_instr) begin
            n_fail++; $display("FAIL ifid: got v=%b i=%h want v=%b i=%h",
                               IFID_Valid, IFID_Instruction, m_valid, m_instr);
        end
        if (m_valid) begin
            n_tests++;
            if (IFID_PCPlus4 !== m_pc4) begin
                n_fail++; $display("FAIL ifid_pc4: got %h want %h", IFID_PCPlus4, m_pc4);
            end
        end
        n_tests++;
        if (PC !== m_pc) begin
            n_fail++; $display("FAIL pc: got %h want %h", PC, m_pc);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if (PC !== 32'h0 || IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 ||
            IFID_PCPlus4 !== 32'h0 || imem.IMemReq !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got pc=%h v=%b i=%h p4=%h req=%b want pc=0 v=0 i=0 p4=0 req=1",
                     tag, PC, IFID_Valid, IFID_Instruction, IFID_PCPlus4, imem.IMemReq);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_values("reset");
        model_reset();
        @(negedge Clk);
        Rst = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
            n_tests++;
            if (IFID_Valid !== 1'b1 || IFID_PCPlus4 !== 32'(4 * (i + 1)) ||
                IFID_Instruction !== mem_word(32'(4 * i))) begin
                n_fail++; $display("FAIL b2b[%0d]: got v=%b p4=%h i=%h want v=1 p4=%h i=%h", i,
                                   IFID_Valid, IFID_PCPlus4, IFID_Instruction,
                                   32'(4 * (i + 1)), mem_word(32'(4 * i)));
            end
            $display("[TB] b2b fetch %0d pc4=%h", i, IFID_PCPlus4);
        end
    endtask

    task automatic test_ack_delay();
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (imem.IMemAddr !== 32'h10) begin
                n_fail++; $display("FAIL delay_addr: got %h want 00000010", imem.IMemAddr);
            end
            cycle(1, k == 2, 0, 32'h0, 0, 32'h0, 0);
        end
        n_tests++;
        if (IFID_Valid !== 1'b1 || IFID_Instruction !== mem_word(32'h10) || IFID_PCPlus4 !== 32'h14) begin
            n_fail++; $display("FAIL delay_data: got v=%b i=%h p4=%h want v=1 i=%h p4=00000014",
                               IFID_Valid, IFID_Instruction, IFID_PCPlus4, mem_word(32'h10));
        end
        $display("[TB] delayed ack delivered pc4=%h", IFID_PCPlus4);
        repeat (3) cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic test_stall_hold();
        cycle(0, 1, 0, 32'h0, 0, 32'h0, 0);
        repeat (2) begin
            cycle(0, 0, 0, 32'h0, 0, 32'h0, 0);
            n_tests++;
            if (imem.IMemReq !== 1'b0 || IFID_PCPlus4 !== 32'h20 || PC !== 32'h20) begin
                n_fail++; $display("FAIL hold: got req=%b p4=%h pc=%h want req=0 p4=00000020 pc=00000020",
                                   imem.IMemReq, IFID_PCPlus4, PC);
            end
        end
        cycle(1, 0, 0, 32'h0, 0, 32'h0, 0);
        n_tests++;
        if (IFID_Instruction !== mem_word(32'h20) || IFID_Valid !== 1'b1 || PC !== 32'h24) begin
            n_fail++; $display("FAIL hold_release: got i=%h v=%b pc=%h want i=%h v=1 pc=00000024",
                               IFID_Instruction, IFID_Valid, PC, mem_word(32'h20));
        end
        $display("[TB] hold released pc=%h", PC);
        repeat (3) cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic test_branch_pending();
        cycle(1, 0, 1, 32'h100, 0, 32'h0, 0);
        n_tests++;
        if (imem.IMemAddr !== 32'h30) begin
            n_fail++; $display("FAIL pend_addr: got %h want 00000030", imem.IMemAddr);
        end
        cycle(1, 0, 0, 32'h0, 0, 32'h0, 0);
        cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
        n_tests++;
        if (IFID_Valid !== 1'b0 || imem.IMemAddr !== 32'h100) begin
            n_fail++; $display("FAIL pend_redirect: got v=%b addr=%h want v=0 addr=00000100",
                               IFID_Valid, imem.IMemAddr);
        end
        $display("[TB] pending branch addr=%h", imem.IMemAddr);
    endtask

    task automatic test_jump_vs_branch();
        cycle(1, 1, 1, 32'h300, 1, 32'h200, 0);
        n_tests++;
        if (IFID_Valid !== 1'b0 || imem.IMemAddr !== 32'h200) begin
            n_fail++; $display("FAIL jump_prio: got v=%b addr=%h want v=0 addr=00000200",
                               IFID_Valid, imem.IMemAddr);
        end
        $display("[TB] jump+branch addr=%h", imem.IMemAddr);
    endtask

    task automatic test_flush();
        cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
        cycle(0, 0, 0, 32'h0, 0, 32'h0, 1);
        n_tests++;
        if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || PC !== 32'h204) begin
            n_fail++; $display("FAIL flush: got v=%b i=%h pc=%h want v=0 i=00000000 pc=00000204",
                               IFID_Valid, IFID_Instruction, PC);
        end
        $display("[TB] flush during stall pc=%h", PC);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            bit          pw  = ($urandom_range(3) != 0);
            bit          ack = !m_holding && ($urandom_range(2) == 0);
            bit          bt  = ($urandom_range(9) == 0);
            bit          jt  = ($urandom_range(13) == 0);
            bit          fl  = ($urandom_range(7) == 0);
            logic [31:0] bta = $urandom;
            logic [31:0] jta = $urandom;
            cycle(pw, ack, bt, bta, jt, jta, fl);
        end
        $display("[TB] random block of %0d cycles done, pc=%h", n, PC);
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 1, 32'hABC0, 0, 32'h0, 0);
        Rst = 1'b0;
        #1;
        check_reset_values("reset_mid");
        model_reset();
        @(negedge Clk);
        Rst = 1'b1;
        cycle(1, 1, 0, 32'h0, 0, 32'h0, 0);
        $display("[TB] mid-run reset, first fetch pc4=%h", IFID_PCPlus4);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_ack_delay();
        test_stall_hold();
        test_branch_pending();
        test_jump_vs_branch();
        test_flush();
        test_random(1500);
        test_reset_mid();
        test_random(1500);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
